// File: rtl/sram_pkg.sv
// Shared definitions for the masked single-port SRAM: the init/run state
// encoding, the legal read-latency range and elaboration helper functions.
package sram_pkg;

    // Operating phase of the memory: sweeping INIT_VAL into the array, or serving requests
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sram_state_e;

    // Read latency may be one cycle (array output register) or two (plus a copy stage)
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 2;

    // Width of one write-mask lane
    localparam int BYTE_W = 8;

    function automatic bit is_legal_latency(input int lat);
        return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
    endfunction

    function automatic bit is_byte_multiple(input int width);
        return (width > 0) && ((width % BYTE_W) == 0);
    endfunction

endpackage : sram_pkg

// File: rtl/sram_init_seq.sv
// Init sweep sequencer: after reset walks a pointer across every word so the
// array can be filled with the init value, then raises ready and stays in RUN
// until the next reset. All outputs are registered.
module sram_init_seq
    import sram_pkg::*;
#(
    parameter int DEPTH = 3072,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    output logic          ready,
    output logic [AW-1:0] init_addr,
    output logic          init_we
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    sram_state_e state;

    // Sweep FSM: one word per cycle in INIT, the last word hands over to RUN
    // NOTE: state registers use non-blocking (<=) so every flop samples the pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_INIT;
            init_addr <= '0;
            init_we   <= 1'b1;
            ready     <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_addr == LAST_ADDR) begin
                        state   <= ST_RUN;
                        init_we <= 1'b0;
                        ready   <= 1'b1;
                    end else begin
                        init_addr <= init_addr + 1'b1;
                    end
                end
                ST_RUN: begin
                    init_we <= 1'b0;
                    ready   <= 1'b1;
                end
                default: begin
                    state     <= ST_INIT;
                    init_addr <= '0;
                    init_we   <= 1'b1;
                    ready     <= 1'b0;
                end
            endcase
        end
    end

endmodule : sram_init_seq

// File: rtl/sram_sp_masked.sv
// Single-port SRAM with per-byte write mask, self-initialising sweep after
// reset and a 1- or 2-cycle read pipeline with a one-cycle rvalid pulse.
// Addresses at or beyond DEPTH drop writes and read back zero.
// Optional build macro: SRAM_GARBAGE_READ_EN -- when defined, RW0_rdata shows
// a fresh pseudo-random value every cycle that RW0_rvalid is low; otherwise
// RW0_rdata holds the last read result.
module sram_sp_masked
    import sram_pkg::*;
#(
    parameter int                DEPTH    = 3072,
    parameter int                DATA_W   = 32,
    parameter int                LATENCY  = 1,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [$clog2(DEPTH)-1:0] RW0_addr,
    input  logic                     RW0_en,
    input  logic                     RW0_wmode,
    input  logic [DATA_W/8-1:0]      RW0_wmask,
    input  logic [DATA_W-1:0]        RW0_wdata,
    output logic [DATA_W-1:0]        RW0_rdata,
    output logic                     RW0_rvalid,
    output logic                     ready
);

    localparam int  AW       = $clog2(DEPTH);
    localparam int  NB       = DATA_W / BYTE_W;
    localparam bit  FULL_MAP = (DEPTH == (1 << AW));

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (!is_legal_latency(LATENCY)) begin : g_bad_latency
        $error("sram_sp_masked: LATENCY must be 1 or 2");
    end
    if (!is_byte_multiple(DATA_W)) begin : g_bad_width
        $error("sram_sp_masked: DATA_W must be a positive multiple of 8");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("sram_sp_masked: DEPTH must be at least 2");
    end

    // ------------------------------------------------------------------
    // Init sweep sequencer
    // ------------------------------------------------------------------
    logic [AW-1:0] init_addr;
    logic          init_we;

    sram_init_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_init_seq (
        .clock     (clock),
        .reset     (reset),
        .ready     (ready),
        .init_addr (init_addr),
        .init_we   (init_we)
    );

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic in_range;

    // A power-of-two depth covers the whole address space, so only odd sizes need the bound
    if (FULL_MAP) begin : g_full_map
        assign in_range = 1'b1;
    end else begin : g_part_map
        assign in_range = (RW0_addr < AW'(DEPTH));
    end

    logic sweep_we;
    logic accept;
    logic acc_wr;
    logic acc_rd;

    // Qualify the strobe with ready; only in-range writes reach the array
    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sweep_we = 1'b0;
        accept   = 1'b0;
        acc_wr   = 1'b0;
        acc_rd   = 1'b0;
        sweep_we = init_we & ~reset;
        accept   = RW0_en & ready;
        acc_wr   = accept & RW0_wmode & in_range;
        acc_rd   = accept & ~RW0_wmode;
    end

    // ------------------------------------------------------------------
    // Storage array
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [DEPTH];

    // Array write port: sweep fill during INIT, byte-masked writes during RUN
    // NOTE: the array has no reset branch; contents are established by the sweep, which keeps it mappable onto RAM macros.
    always_ff @(posedge clock) begin
        if (sweep_we) begin
            mem[init_addr] <= INIT_VAL;
        end else if (acc_wr) begin
            for (int b = 0; b < NB; b++) begin
                if (RW0_wmask[b]) begin
                    mem[RW0_addr][b*BYTE_W +: BYTE_W] <= RW0_wdata[b*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------
    logic              rd_v1;
    logic [DATA_W-1:0] rd_d1;

    // First read stage: the only place the array is read; holds data between reads
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_v1 <= 1'b0;
            rd_d1 <= '0;
        end else begin
            rd_v1 <= acc_rd;
            if (acc_rd) begin
                rd_d1 <= in_range ? mem[RW0_addr] : '0;
            end
        end
    end

    logic              out_v;
    logic [DATA_W-1:0] out_d;

    if (LATENCY == 2) begin : g_lat2
        logic              rd_v2;
        logic [DATA_W-1:0] rd_d2;

        // Second read stage: a registered copy of the first, never a second array access
        always_ff @(posedge clock) begin
            if (reset) begin
                rd_v2 <= 1'b0;
                rd_d2 <= '0;
            end else begin
                rd_v2 <= rd_v1;
                if (rd_v1) begin
                    rd_d2 <= rd_d1;
                end
            end
        end

        assign out_v = rd_v2;
        assign out_d = rd_d2;
    end else begin : g_lat1
        assign out_v = rd_v1;
        assign out_d = rd_d1;
    end

    assign RW0_rvalid = out_v;

`ifdef SRAM_GARBAGE_READ_EN
    localparam int REP = (DATA_W + 31) / 32;

    logic [31:0]       lfsr;
    logic [REP*32-1:0] garbage_wide;

    // Free-running 32-bit LFSR (taps 32,22,2,1) supplying a new filler word every cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= 32'hACE1_2468;
        end else begin
            lfsr <= {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
        end
    end

    assign garbage_wide = {REP{lfsr}};
    assign RW0_rdata    = out_v ? out_d : garbage_wide[DATA_W-1:0];
`else
    assign RW0_rdata = out_d;
`endif

endmodule : sram_sp_masked
